math_block_simd: RTL

Parametrised next-generation math block for the eFPGA math unit. It performs SIMD multiply-accumulate over DATA_W-bit operands split into 1, 2, 4 or 8 lanes, with a programmable accumulation length, rounding/saturating output formatting, and a valid handshake. It sits between the eFPGA fabric / TPRAM operand sources and the eFPGA result bus.

---
 rtl/math_block_simd.sv | 356 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/math_block_simd.sv
// ---------------------------------------------------------------------------
// math_block_simd
//
// SIMD multiply-accumulate block for the eFPGA math unit. The DATA_W-bit
// operand and coefficient are split into 1, 2, 4 or 8 lanes. Each lane
// accumulates ACC_LEN+1 products and then rounds, shifts and saturates or
// wraps the sum into its lane of the packed result.
//
// Pipeline:
//   stage 0 : registers the selected operand pair with MODE and TC
//   stage 1 : per-lane multiply-accumulate with product counter
//   stage 2 : per-lane round / shift / range check / saturate, output register
//
// Ports:
//   EFPGA2MATHB_CLK           sole clock
//   reset                     synchronous active-high reset (highest priority)
//   EFPGA_MATHB_CLK_EN        global enable; low freezes all state
//   TPRAM_MATHB_OPER_R_DATA   operand from TPRAM
//   EFPGA_MATHB_OPER_DATA     operand from eFPGA fabric
//   EFPGA_MATHB_OPER_defPin   operand source: 0x = eFPGA, 10 = TPRAM, 11 = SEL
//   EFPGA_MATHB_OPER_SEL      1 = TPRAM when defPin = 11
//   *_COEF_*                  same four signals for the coefficient
//   EFPGA_MATHB_IN_VALID      operand pair valid
//   EFPGA_MATHB_MODE          lane count = 1 << MODE
//   EFPGA_MATHB_TC_defPin     1 = signed lanes, 0 = unsigned lanes
//   EFPGA_MATHB_ACC_LEN       products per result minus one
//   EFPGA_MATHB_MAC_OUT_SEL   right-shift applied to each lane sum
//   EFPGA_MATHB_MAC_ACC_RND   round-half-up before the shift
//   EFPGA_MATHB_MAC_ACC_SAT   saturate out-of-range lanes instead of wrapping
//   EFPGA_MATHB_MAC_ACC_CLEAR drop the partial result and restart counting
//   FMATHB_EFPGA_MAC_OUT      packed lane results, lane 0 at the LSBs
//   FMATHB_EFPGA_MAC_VALID    one enabled cycle strobe per result
//   FMATHB_EFPGA_ACC_OVF      at least one lane of the result was out of range
// ---------------------------------------------------------------------------
module math_block_simd #(
    parameter int DATA_W    = 32,
    parameter int ACC_GUARD = 8,
    parameter int CNT_W     = 8
) (
    input  logic              EFPGA2MATHB_CLK,
    input  logic              reset,
    input  logic              EFPGA_MATHB_CLK_EN,
    input  logic [DATA_W-1:0] TPRAM_MATHB_OPER_R_DATA,
    input  logic [DATA_W-1:0] EFPGA_MATHB_OPER_DATA,
    input  logic [1:0]        EFPGA_MATHB_OPER_defPin,
    input  logic              EFPGA_MATHB_OPER_SEL,
    input  logic [DATA_W-1:0] TPRAM_MATHB_COEF_R_DATA,
    input  logic [DATA_W-1:0] EFPGA_MATHB_COEF_DATA,
    input  logic [1:0]        EFPGA_MATHB_COEF_defPin,
    input  logic              EFPGA_MATHB_COEF_SEL,
    input  logic              EFPGA_MATHB_IN_VALID,
    input  logic [1:0]        EFPGA_MATHB_MODE,
    input  logic              EFPGA_MATHB_TC_defPin,
    input  logic [CNT_W-1:0]  EFPGA_MATHB_ACC_LEN,
    input  logic [5:0]        EFPGA_MATHB_MAC_OUT_SEL,
    input  logic              EFPGA_MATHB_MAC_ACC_RND,
    input  logic              EFPGA_MATHB_MAC_ACC_SAT,
    input  logic              EFPGA_MATHB_MAC_ACC_CLEAR,
    output logic [DATA_W-1:0] FMATHB_EFPGA_MAC_OUT,
    output logic              FMATHB_EFPGA_MAC_VALID,
    output logic              FMATHB_EFPGA_ACC_OVF
);

    // Storage is sized for the widest case of every mode: 8 lane slots, each
    // wide enough for the single-lane accumulator. Narrower modes use the
    // low lane slots and keep their values canonically extended to AW bits.
    localparam int LANES = 8;
    localparam int AW    = 2 * DATA_W + ACC_GUARD;
    // Two extra bits so the rounding increment can never reach the sign bit,
    // even for an unsigned accumulator that is already at its maximum.
    localparam int FW    = AW + 2;

    // Extract lane 'lane' of 'word' for the given mode and extend it to AW
    // bits, sign-extending when tc is set.
    function automatic logic [AW-1:0] extend_lane(input logic [DATA_W-1:0] word,
                                                  input int lane,
                                                  input logic [1:0] mode,
                                                  input logic tc);
        int                lw;
        logic [DATA_W-1:0] keep;
        logic [DATA_W-1:0] field;
        logic [AW-1:0]     ext;
        lw    = DATA_W >> mode;
        keep  = {DATA_W{1'b1}} >> (DATA_W - lw);
        field = (word >> (lane * lw)) & keep;
        ext   = AW'(field);
        if (tc && (|(field & ~(keep >> 1)))) begin
            ext = ext | ~AW'(keep);
        end
        return ext;
    endfunction

    // Reduce a value modulo 2^width and re-extend it to AW bits so the
    // stored accumulator always wraps at its architectural width.
    function automatic logic [AW-1:0] wrap_acc(input logic [AW-1:0] value,
                                               input int width,
                                               input logic tc);
        logic [AW-1:0] keep;
        logic [AW-1:0] res;
        keep = {AW{1'b1}} >> (AW - width);
        res  = value & keep;
        if (tc && (|(value & keep & ~(keep >> 1)))) begin
            res = res | ~keep;
        end
        return res;
    endfunction

    // Source selection
    logic              oper_from_tpram;
    logic              coef_from_tpram;
    logic [DATA_W-1:0] oper_sel;
    logic [DATA_W-1:0] coef_sel;

    // Stage 0 registers
    logic              s0_valid;
    logic [DATA_W-1:0] s0_oper;
    logic [DATA_W-1:0] s0_coef;
    logic [1:0]        s0_mode;
    logic              s0_tc;

    // Per-result configuration captured with the first product
    logic [1:0]        cfg_mode;
    logic              cfg_tc;
    logic [CNT_W-1:0]  cfg_len;
    logic [5:0]        cfg_shift;
    logic              cfg_rnd;
    logic              cfg_sat;

    // Stage 1 state and combinational results
    logic [AW-1:0]     acc [LANES];
    logic [CNT_W-1:0]  count;
    logic              first_prod;
    logic              last_prod;
    logic [1:0]        eff_mode;
    logic              eff_tc;
    logic [CNT_W-1:0]  eff_len;
    logic [5:0]        eff_shift;
    logic              eff_rnd;
    logic              eff_sat;
    int                acc_lanes;
    int                acc_w;
    logic [AW-1:0]     op_a;
    logic [AW-1:0]     op_b;
    logic [AW-1:0]     lane_sum [LANES];

    // Stage 1 -> stage 2 registers
    logic              s1_valid;
    logic [AW-1:0]     s1_sum [LANES];
    logic [1:0]        s1_mode;
    logic              s1_tc;
    logic [5:0]        s1_shift;
    logic              s1_rnd;
    logic              s1_sat;

    // Stage 2 combinational results
    int                fmt_lw;
    int                fmt_w2;
    int                fmt_k;
    int                fmt_lanes;
    logic signed [FW-1:0] fmt_v;
    logic signed [FW-1:0] fmt_res;
    logic signed [FW-1:0] fmt_max;
    logic signed [FW-1:0] fmt_min;
    logic [DATA_W-1:0] fmt_mask;
    logic [DATA_W-1:0] fmt_field;
    logic [DATA_W-1:0] fmt_out;
    logic              fmt_ovf;

    // Output registers
    logic [DATA_W-1:0] out_data;
    logic              out_ovf;
    logic              out_valid;

    // Operand and coefficient each pick TPRAM or eFPGA independently;
    // defPin 11 defers the choice to the per-cycle SEL input.
    always_comb begin
        oper_from_tpram = (EFPGA_MATHB_OPER_defPin == 2'b10) ||
                          ((EFPGA_MATHB_OPER_defPin == 2'b11) && EFPGA_MATHB_OPER_SEL);
        coef_from_tpram = (EFPGA_MATHB_COEF_defPin == 2'b10) ||
                          ((EFPGA_MATHB_COEF_defPin == 2'b11) && EFPGA_MATHB_COEF_SEL);
        oper_sel = oper_from_tpram ? TPRAM_MATHB_OPER_R_DATA : EFPGA_MATHB_OPER_DATA;
        coef_sel = coef_from_tpram ? TPRAM_MATHB_COEF_R_DATA : EFPGA_MATHB_COEF_DATA;
    end

    // Stage 0: capture a valid pair with its lane format. A CLEAR does not
    // block this capture; the pair taken at the CLEAR edge starts a new result.
    always_ff @(posedge EFPGA2MATHB_CLK) begin
        if (reset) begin
            s0_valid <= 1'b0;
            s0_oper  <= '0;
            s0_coef  <= '0;
            s0_mode  <= '0;
            s0_tc    <= 1'b0;
        end else if (EFPGA_MATHB_CLK_EN) begin
            s0_valid <= EFPGA_MATHB_IN_VALID;
            if (EFPGA_MATHB_IN_VALID) begin
                s0_oper <= oper_sel;
                s0_coef <= coef_sel;
                s0_mode <= EFPGA_MATHB_MODE;
                s0_tc   <= EFPGA_MATHB_TC_defPin;
            end
        end
    end

    // Stage 1 datapath. On the first product of a result the live settings
    // are used (and latched below); later products reuse the latched copy so
    // mid-result changes only affect the next result.
    always_comb begin
        first_prod = (count == '0);
        eff_mode   = first_prod ? s0_mode                 : cfg_mode;
        eff_tc     = first_prod ? s0_tc                   : cfg_tc;
        eff_len    = first_prod ? EFPGA_MATHB_ACC_LEN     : cfg_len;
        eff_shift  = first_prod ? EFPGA_MATHB_MAC_OUT_SEL : cfg_shift;
        eff_rnd    = first_prod ? EFPGA_MATHB_MAC_ACC_RND : cfg_rnd;
        eff_sat    = first_prod ? EFPGA_MATHB_MAC_ACC_SAT : cfg_sat;
        last_prod  = (count == eff_len);
        acc_lanes  = 1 << eff_mode;
        acc_w      = 2 * (DATA_W >> eff_mode) + ACC_GUARD;
        op_a       = '0;
        op_b       = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum[i] = '0;
            if (i < acc_lanes) begin
                op_a        = extend_lane(s0_oper, i, eff_mode, eff_tc);
                op_b        = extend_lane(s0_coef, i, eff_mode, eff_tc);
                lane_sum[i] = wrap_acc(acc[i] + op_a * op_b, acc_w, eff_tc);
            end
        end
    end

    // Stage 1 state. The last product hands its sum to stage 2 and reloads
    // the accumulator in the same edge, so consecutive results need no gap.
    always_ff @(posedge EFPGA2MATHB_CLK) begin
        if (reset) begin
            count     <= '0;
            cfg_mode  <= '0;
            cfg_tc    <= 1'b0;
            cfg_len   <= '0;
            cfg_shift <= '0;
            cfg_rnd   <= 1'b0;
            cfg_sat   <= 1'b0;
            s1_valid  <= 1'b0;
            s1_mode   <= '0;
            s1_tc     <= 1'b0;
            s1_shift  <= '0;
            s1_rnd    <= 1'b0;
            s1_sat    <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc[i]    <= '0;
                s1_sum[i] <= '0;
            end
        end else if (EFPGA_MATHB_CLK_EN) begin
            s1_valid <= 1'b0;
            if (EFPGA_MATHB_MAC_ACC_CLEAR) begin
                count <= '0;
                for (int i = 0; i < LANES; i++) begin
                    acc[i] <= '0;
                end
            end else if (s0_valid) begin
                if (first_prod) begin
                    cfg_mode  <= eff_mode;
                    cfg_tc    <= eff_tc;
                    cfg_len   <= eff_len;
                    cfg_shift <= eff_shift;
                    cfg_rnd   <= eff_rnd;
                    cfg_sat   <= eff_sat;
                end
                if (last_prod) begin
                    count    <= '0;
                    s1_valid <= 1'b1;
                    s1_mode  <= eff_mode;
                    s1_tc    <= eff_tc;
                    s1_shift <= eff_shift;
                    s1_rnd   <= eff_rnd;
                    s1_sat   <= eff_sat;
                    for (int i = 0; i < LANES; i++) begin
                        acc[i]    <= '0;
                        s1_sum[i] <= lane_sum[i];
                    end
                end else begin
                    count <= count + 1'b1;
                    for (int i = 0; i < LANES; i++) begin
                        acc[i] <= lane_sum[i];
                    end
                end
            end
        end
    end

    // Stage 2 formatting. Sums arrive canonically extended, so widening by two
    // bits with the lane sign gives an exact signed value to round and shift.
    // An arithmetic shift of a non-negative unsigned value equals a logical one.
    always_comb begin
        fmt_lw    = DATA_W >> s1_mode;
        fmt_w2    = 2 * fmt_lw + ACC_GUARD;
        fmt_lanes = 1 << s1_mode;
        fmt_k     = int'(s1_shift);
        if (fmt_k >= fmt_w2) begin
            fmt_k = fmt_w2 - 1;
        end
        fmt_max   = s1_tc ? ((FW'(1) << (fmt_lw - 1)) - FW'(1))
                          : ((FW'(1) << fmt_lw) - FW'(1));
        fmt_min   = s1_tc ? -(FW'(1) << (fmt_lw - 1)) : '0;
        fmt_mask  = {DATA_W{1'b1}} >> (DATA_W - fmt_lw);
        fmt_out   = '0;
        fmt_ovf   = 1'b0;
        fmt_v     = '0;
        fmt_res   = '0;
        fmt_field = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < fmt_lanes) begin
                fmt_v = {{2{s1_tc & s1_sum[i][AW-1]}}, s1_sum[i]};
                if (s1_rnd && (fmt_k > 0)) begin
                    fmt_v = fmt_v + (FW'(1) << (fmt_k - 1));
                end
                fmt_v = fmt_v >>> fmt_k;
                if ((fmt_v > fmt_max) || (fmt_v < fmt_min)) begin
                    fmt_ovf = 1'b1;
                end
                fmt_res = fmt_v;
                if (s1_sat) begin
                    if (fmt_v > fmt_max) begin
                        fmt_res = fmt_max;
                    end else if (fmt_v < fmt_min) begin
                        fmt_res = fmt_min;
                    end
                end
                fmt_field = DATA_W'(fmt_res) & fmt_mask;
                fmt_out   = fmt_out | (fmt_field << (i * fmt_lw));
            end
        end
    end

    // Output register: data and overflow hold between results, the strobe
    // register lasts one enabled cycle.
    always_ff @(posedge EFPGA2MATHB_CLK) begin
        if (reset) begin
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (EFPGA_MATHB_CLK_EN) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= fmt_out;
                out_ovf  <= fmt_ovf;
            end
        end
    end

    // The strobe is masked while stalled so it is seen in exactly one
    // enabled cycle even if the enable drops right after it is registered.
    assign FMATHB_EFPGA_MAC_OUT   = out_data;
    assign FMATHB_EFPGA_ACC_OVF   = out_ovf;
    assign FMATHB_EFPGA_MAC_VALID = out_valid & EFPGA_MATHB_CLK_EN;

endmodule
